// File: rtl/nibble_packer.sv
// Packs a stream of 4-bit nibbles (LSB first) into NIBBLES_PER_WORD-nibble words behind a one-entry output buffer.
// Optional `define NIBBLE_PACKER_MAX_EN adds MAX_NIBBLE, the largest nibble of each emitted word.
module nibble_packer #(
  parameter int NIBBLES_PER_WORD = 8,
  parameter int CNT_W            = 4
) (
  input  logic                          CLK,
  input  logic                          RESET,
  input  logic [3:0]                    NIBBLE_IN,
  input  logic                          NIBBLE_VALID,
  output logic                          NIBBLE_READY,
  input  logic                          FLUSH,
  output logic [4*NIBBLES_PER_WORD-1:0] DATA_OUT,
  output logic                          DATA_VALID,
  input  logic                          DATA_READY,
  output logic [CNT_W-1:0]              NIBBLE_COUNT
`ifdef NIBBLE_PACKER_MAX_EN
  ,
  output logic [3:0]                    MAX_NIBBLE
`endif
);

  localparam int                W        = 4 * NIBBLES_PER_WORD;
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NIBBLES_PER_WORD - 1);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } out_state_e;

  out_state_e       state_r;
  out_state_e       state_next_s;
  logic [CNT_W-1:0] cnt_r;
  logic [CNT_W-1:0] cnt_inc_s;
  logic [W-1:0]     asm_r;
  logic [W-1:0]     merged_s;
  logic [W-1:0]     data_r;
  logic [CNT_W-1:0] count_r;
  logic             last_s;
  logic             accept_s;
  logic             can_load_s;
  logic             close_s;
  logic             nibble_ready_s;

  // Handshake decode: ready only drops when a close would be needed but the buffer cannot take it.
  always_comb begin
    last_s         = (cnt_r == LAST_IDX);
    nibble_ready_s = !((state_r == FULL) && !DATA_READY && (last_s || FLUSH));
    accept_s       = NIBBLE_VALID && nibble_ready_s;
    can_load_s     = (state_r == EMPTY) || DATA_READY;
    close_s        = can_load_s &&
                     ((accept_s && last_s) || (FLUSH && ((cnt_r != '0) || accept_s)));
    cnt_inc_s      = cnt_r + {{(CNT_W-1){1'b0}}, accept_s};
  end

  // Assembly word including this cycle's nibble; unfilled slots are already zero.
  always_comb begin
    merged_s = asm_r;
    for (int k = 0; k < NIBBLES_PER_WORD; k++) begin
      if (accept_s && (cnt_r == CNT_W'(k))) begin
        merged_s[4*k +: 4] = NIBBLE_IN;
      end else begin
        merged_s[4*k +: 4] = asm_r[4*k +: 4];
      end
    end
  end

  // Output buffer next state: a close refills it even while it is being drained.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      EMPTY: begin
        if (close_s) begin
          state_next_s = FULL;
        end else begin
          state_next_s = EMPTY;
        end
      end
      FULL: begin
        if (close_s) begin
          state_next_s = FULL;
        end else if (DATA_READY) begin
          state_next_s = EMPTY;
        end else begin
          state_next_s = FULL;
        end
      end
      default: state_next_s = EMPTY;
    endcase
  end

  // Output buffer state register.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_r <= EMPTY;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Assembly register and nibble counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      asm_r <= '0;
      cnt_r <= '0;
    end else if (close_s) begin
      asm_r <= '0;
      cnt_r <= '0;
    end else if (accept_s) begin
      asm_r <= merged_s;
      cnt_r <= cnt_inc_s;
    end else begin
      asm_r <= asm_r;
      cnt_r <= cnt_r;
    end
  end

  // Output word and count, loaded only on a close so they stay stable under backpressure.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      data_r  <= '0;
      count_r <= '0;
    end else if (close_s) begin
      data_r  <= merged_s;
      count_r <= cnt_inc_s;
    end else begin
      data_r  <= data_r;
      count_r <= count_r;
    end
  end

`ifdef NIBBLE_PACKER_MAX_EN
  logic [3:0] run_max_r;
  logic [3:0] run_max_next_s;
  logic [3:0] max_r;

  // Running maximum over accepted nibbles of the word being assembled.
  always_comb begin
    if (accept_s && (NIBBLE_IN > run_max_r)) begin
      run_max_next_s = NIBBLE_IN;
    end else begin
      run_max_next_s = run_max_r;
    end
  end

  // Running max restarts on each close; the emitted max travels with DATA_OUT.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      run_max_r <= 4'h0;
      max_r     <= 4'h0;
    end else if (close_s) begin
      run_max_r <= 4'h0;
      max_r     <= run_max_next_s;
    end else begin
      run_max_r <= run_max_next_s;
      max_r     <= max_r;
    end
  end

  assign MAX_NIBBLE = max_r;
`endif

  assign NIBBLE_READY = nibble_ready_s;
  assign DATA_OUT     = data_r;
  assign DATA_VALID   = (state_r == FULL);
  assign NIBBLE_COUNT = count_r;

endmodule

// File: tb/tb_nibble_packer.sv
// Randomized + directed bench for nibble_packer with a queue-based reference model and scoreboard monitor.
module tb_nibble_packer;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [3:0]  NIBBLE_IN;
  logic        NIBBLE_VALID;
  logic        NIBBLE_READY;
  logic        FLUSH;
  logic [31:0] DATA_OUT;
  logic        DATA_VALID;
  logic        DATA_READY;
  logic [3:0]  NIBBLE_COUNT;
`ifdef NIBBLE_PACKER_MAX_EN
  logic [3:0]  MAX_NIBBLE;
`endif

  nibble_packer #(.NIBBLES_PER_WORD(8), .CNT_W(4)) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .NIBBLE_IN    (NIBBLE_IN),
    .NIBBLE_VALID (NIBBLE_VALID),
    .NIBBLE_READY (NIBBLE_READY),
    .FLUSH        (FLUSH),
    .DATA_OUT     (DATA_OUT),
    .DATA_VALID   (DATA_VALID),
    .DATA_READY   (DATA_READY),
    .NIBBLE_COUNT (NIBBLE_COUNT)
`ifdef NIBBLE_PACKER_MAX_EN
    ,
    .MAX_NIBBLE   (MAX_NIBBLE)
`endif
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [31:0] word;
    logic [3:0]  cnt;
    logic [3:0]  mx;
  } exp_t;

  exp_t       expq[$];
  logic [3:0] cur[$];
  bit         pending = 1'b0;
  bit         started = 1'b0;
  int         checks  = 0;
  int         errors  = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: a word is simply the list of nibbles gathered since the last close.
  always @(negedge CLK) begin
    if (started && !RESET) begin
      bit   exp_ready, acc, can_load, close;
      exp_t e;
      exp_ready = !(pending && !DATA_READY && ((cur.size() == 7) || FLUSH));
      chk("nibble_ready", {31'd0, NIBBLE_READY}, {31'd0, exp_ready});
      chk("data_valid", {31'd0, DATA_VALID}, {31'd0, pending});
      acc = NIBBLE_VALID && exp_ready;
      if (acc) cur.push_back(NIBBLE_IN);
      can_load = !pending || DATA_READY;
      close = can_load && ((acc && (cur.size() == 8)) || (FLUSH && (cur.size() > 0)));
      if (close) begin
        e.word = 32'd0;
        e.mx   = 4'd0;
        for (int k = 0; k < cur.size(); k++) begin
          e.word = e.word | (32'(cur[k]) << (4 * k));
          if (cur[k] > e.mx) e.mx = cur[k];
        end
        e.cnt = 4'(cur.size());
        expq.push_back(e);
        cur.delete();
        pending = 1'b1;
      end else if (pending && DATA_READY) begin
        pending = 1'b0;
      end
    end
  end

  // Monitor: compares whatever the DUT presents against the oldest expected word.
  always @(negedge CLK) begin
    if (started && !RESET && DATA_VALID) begin
      if (expq.size() == 0) begin
        chk("unexpected_word", DATA_OUT, 32'hxxxxxxxx);
      end else begin
        chk("sb_data", DATA_OUT, expq[0].word);
        chk("sb_count", {28'd0, NIBBLE_COUNT}, {28'd0, expq[0].cnt});
`ifdef NIBBLE_PACKER_MAX_EN
        chk("sb_max", {28'd0, MAX_NIBBLE}, {28'd0, expq[0].mx});
`endif
        if (DATA_READY) void'(expq.pop_front());
      end
    end
  end

  task automatic cyc(input bit v, input logic [3:0] n, input bit f, input bit d);
    NIBBLE_VALID = v;
    NIBBLE_IN    = n;
    FLUSH        = f;
    DATA_READY   = d;
    @(posedge CLK);
    #2;
  endtask

  initial begin
    RESET = 1'b1; NIBBLE_VALID = 1'b0; NIBBLE_IN = 4'h0; FLUSH = 1'b0; DATA_READY = 1'b0;
    repeat (2) @(posedge CLK);
    #2;
    chk("rst_data", DATA_OUT, 32'd0);
    chk("rst_valid", {31'd0, DATA_VALID}, 32'd0);
    chk("rst_count", {28'd0, NIBBLE_COUNT}, 32'd0);
`ifdef NIBBLE_PACKER_MAX_EN
    chk("rst_max", {28'd0, MAX_NIBBLE}, 32'd0);
`endif
    RESET = 1'b0;
    started = 1'b1;
    #1;
    chk("rst_ready", {31'd0, NIBBLE_READY}, 32'd1);
    @(posedge CLK); #2;

    // 1..8 back to back
    for (int i = 1; i <= 8; i++) cyc(1'b1, 4'(i), 1'b0, 1'b1);
    chk("t1_word", DATA_OUT, 32'h87654321);
    chk("t1_count", {28'd0, NIBBLE_COUNT}, 32'd8);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // partial flush, then an ignored flush
    cyc(1'b1, 4'hA, 1'b0, 1'b1);
    cyc(1'b1, 4'hB, 1'b0, 1'b1);
    cyc(1'b1, 4'hC, 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b1, 1'b1);
    chk("t2_word", DATA_OUT, 32'h00000CBA);
    chk("t2_count", {28'd0, NIBBLE_COUNT}, 32'd3);
    cyc(1'b0, 4'h0, 1'b1, 1'b1);
    chk("t2_noempty", {31'd0, DATA_VALID}, 32'd0);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // stalled output: 15 nibbles accepted, 16th waits for DATA_READY
    for (int i = 0; i < 15; i++) cyc(1'b1, 4'(15 - i), 1'b0, 1'b0);
    repeat (3) cyc(1'b1, 4'h0, 1'b0, 1'b0);
    chk("t3_hold", DATA_OUT, 32'h89ABCDEF);
    chk("t3_ready_low", {31'd0, NIBBLE_READY}, 32'd0);
    cyc(1'b1, 4'h0, 1'b0, 1'b1);
    chk("t3_next", DATA_OUT, 32'h01234567);
    chk("t3_valid", {31'd0, DATA_VALID}, 32'd1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // continuous stream, 3 words
    for (int i = 0; i < 24; i++) cyc(1'b1, 4'($urandom_range(0, 15)), 1'b0, 1'b1);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // 7th nibble with flush
    for (int i = 1; i <= 6; i++) cyc(1'b1, 4'(i + 8), 1'b0, 1'b1);
    cyc(1'b1, 4'h3, 1'b1, 1'b1);
    chk("t6_count", {28'd0, NIBBLE_COUNT}, 32'd7);
    chk("t6_top", {28'd0, DATA_OUT[31:28]}, 32'd0);
    chk("t6_word", DATA_OUT, 32'h03EDCBA9);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // async reset with a word buffered and 5 nibbles pending
    for (int i = 0; i < 13; i++) cyc(1'b1, 4'h9, 1'b0, 1'b0);
    #1;
    RESET = 1'b1; NIBBLE_VALID = 1'b0; FLUSH = 1'b0;
    cur.delete(); expq.delete(); pending = 1'b0;
    #1;
    chk("t5_rst_data", DATA_OUT, 32'd0);
    chk("t5_rst_valid", {31'd0, DATA_VALID}, 32'd0);
    chk("t5_rst_count", {28'd0, NIBBLE_COUNT}, 32'd0);
    @(posedge CLK); #2;
    RESET = 1'b0;
    for (int i = 0; i < 8; i++) cyc(1'b1, 4'h5, 1'b0, 1'b1);
    chk("t5_word", DATA_OUT, 32'h55555555);
    chk("t5_count", {28'd0, NIBBLE_COUNT}, 32'd8);
    cyc(1'b0, 4'h0, 1'b0, 1'b1);

    // random traffic
    for (int i = 0; i < 1500; i++)
      cyc($urandom_range(0, 3) != 0, 4'($urandom_range(0, 15)),
          $urandom_range(0, 9) == 0, $urandom_range(0, 3) != 0);

    // drain
    cyc(1'b0, 4'h0, 1'b1, 1'b1);
    repeat (4) cyc(1'b0, 4'h0, 1'b0, 1'b1);
    chk("drain_empty", 32'(expq.size()), 32'd0);
    chk("drain_valid", {31'd0, DATA_VALID}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nibble_packer.md
Name: nibble_packer

Overview:
- Reverse direction of the nibble selection path: accepts a stream of 4-bit nibbles and packs them into 32-bit words.
- The nibble-selection logic splits 32-bit DATA words into nibbles. This block rebuilds words from nibbles for downstream consumers, e.g. the loopback checker and the DATA_A/DATA_B sources.
- One assembly register plus a one-entry output buffer, with valid/ready handshakes on both sides.
- A FLUSH input emits partial words, zero-padded.

Parameters:
NIBBLES_PER_WORD, 8, number of nibbles per output word; output width is 4*NIBBLES_PER_WORD (32 by default).
CNT_W, 4, width of the nibble counter and of NIBBLE_COUNT; must hold the value NIBBLES_PER_WORD.

Ports:
CLK  input  1  single clock; all state updates on posedge.
RESET  input  1  asynchronous, active-high reset.
NIBBLE_IN  input  4  incoming nibble.
NIBBLE_VALID  input  1  NIBBLE_IN is valid.
NIBBLE_READY  output  1  packer can accept a nibble this cycle.
FLUSH  input  1  close the current partial word.
DATA_OUT  output  32  packed word; nibble k is DATA_OUT[4k+3:4k].
DATA_VALID  output  1  DATA_OUT holds a word.
DATA_READY  input  1  consumer accepts DATA_OUT.
NIBBLE_COUNT  output  CNT_W  number of valid nibbles in DATA_OUT (1..8).

Behaviour:
- Reset (asynchronous, active-high, one clock; reset port named RESET, clock named CLK):
  - DATA_OUT=0, DATA_VALID=0, NIBBLE_COUNT=0.
  - Assembly register=0, counter cnt=0, output FSM=EMPTY.
  - NIBBLE_READY=1 once RESET deasserts.
  - Asserting RESET mid-word discards partial and buffered data, with no emission.
- Nibble accept: NIBBLE_VALID && NIBBLE_READY at posedge.
  - Nibble is written to assembly[4*cnt+3:4*cnt]; cnt increments.
  - First nibble lands in bits [3:0] (LSB first).
- Word close: a closing event is either
  - an accepted nibble with cnt==NIBBLES_PER_WORD-1, or
  - FLUSH=1 with (cnt>0 or a nibble accepted the same cycle).
- On a close:
  - Output buffer loads assembly (including the same-cycle nibble), upper unfilled nibbles forced to 0.
  - NIBBLE_COUNT = cnt+accepted (1..8).
  - cnt and assembly clear to 0.
  - DATA_VALID rises the next cycle. Latency from last nibble accept to DATA_VALID is 1 cycle.
- FLUSH with cnt==0 and no nibble accepted is ignored; no empty word is ever emitted.
- Output FSM:
  - EMPTY -> FULL on close.
  - FULL -> EMPTY on DATA_READY with no close.
  - FULL -> FULL on DATA_READY plus a simultaneous close (back-to-back words, no bubble).
  - FULL holds while DATA_READY=0; DATA_OUT and NIBBLE_COUNT are stable while DATA_VALID && !DATA_READY.
- Backpressure:
  - NIBBLE_READY = !(FULL && !DATA_READY && (cnt==NIBBLES_PER_WORD-1 || FLUSH)).
  - Filling of nibbles 0..N-2 continues while the output is stalled.
  - NIBBLE_READY depends combinationally on DATA_READY and FLUSH only; no combinational path from NIBBLE_VALID.
- FLUSH during a stall: when it cannot close (FULL && !DATA_READY), it is not remembered. The source must hold FLUSH until a cycle where the close occurs.
- DATA_READY while EMPTY has no effect.
- Sustained throughput: 1 nibble/cycle, 1 word per 8 cycles.

Optional Feature:
NIBBLE_PACKER_MAX_EN
- Defined:
  - Extra output port MAX_NIBBLE[3:0], registered alongside DATA_OUT: the largest valid nibble of the emitted word, unsigned, padding excluded.
  - Running max is tracked during assembly and resets to 0 on close and on RESET.
  - MAX_NIBBLE is 0 after reset.
- Undefined: port and running-max logic are absent. All other behaviour is identical.

Test Plan:
- Reset, then 8 nibbles 1,2,..,8 on consecutive cycles with DATA_READY=1 -> one cycle after the 8th, DATA_VALID=1, DATA_OUT=32'h87654321, NIBBLE_COUNT=8; with MAX_EN, MAX_NIBBLE=8.
- 3 nibbles A,B,C, then FLUSH alone -> DATA_OUT=32'h00000CBA, NIBBLE_COUNT=3. FLUSH with cnt==0 afterwards -> no DATA_VALID pulse.
- DATA_READY=0, send 16 nibbles F,E,...,0 ->
  - first word 32'h89ABCDEF held stable;
  - NIBBLE_READY drops while cnt==7 (15th nibble already accepted);
  - raise DATA_READY -> 32'h01234567 follows the next cycle, no nibble lost.
- Continuous nibbles with DATA_READY=1 for 24 cycles -> 3 words, DATA_VALID contiguous at each 8-cycle boundary with no bubble, NIBBLE_READY constantly 1.
- Assert RESET asynchronously (between clock edges) after 5 nibbles and with a word buffered -> outputs go to 0 immediately. Then 8 nibbles of 4'h5 -> 32'h55555555, with none of the earlier nibbles present.
- 7th nibble accepted with FLUSH=1 the same cycle -> NIBBLE_COUNT=7, bits[31:28]=0.
